muldiv_seq: RTL
===============

// Module: muldiv_seq
// PURPOSE
//  Multi-cycle unsigned MULTU/DIVU sequencer for the pipeline CPU EX stage.
//  Time-shares the existing 32-bit ALU: drives alu_a/alu_b/alu_ctr for one iteration per cycle.
//  Uses the returned alu_y to run shift-add multiply and restoring divide.
//  Raises busy so hazard logic stalls the pipe; results go to HI/LO.
// PARAMETERS
//  WIDTH     32   operand/result width; must match ALU instruction_width
//  CNT_W     5    iteration counter width; 2**CNT_W == WIDTH
// PORTS
//  clk      in   1      rising-edge clock
//  rst      in   1      synchronous, active-high reset
//  start    in   1      launch request; sampled only in IDLE
//  op       in   1      0 = MULTU, 1 = DIVU
//  src_a    in   WIDTH  multiplicand / dividend
//  src_b    in   WIDTH  multiplier / divisor
//  flush    in   1      abort in-flight op (branch/exception squash)
//  busy     out  1      state != IDLE
//  done     out  1      one-cycle pulse; hi/lo valid from this cycle
//  hi       out  WIDTH  MUL: product[63:32]; DIV: remainder
//  lo       out  WIDTH  MUL: product[31:0];  DIV: quotient
//  alu_a    out  WIDTH  ALU operand a
//  alu_b    out  WIDTH  ALU operand b
//  alu_ctr  out  4      ALU control: 4'b0010 ADD, 4'b0110 SUB
//  alu_y    in   WIDTH  ALU result (combinational return, same cycle)
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, done=0, hi=0, lo=0, counter=0; all work regs 0.
//  Idle ALU drive: alu_a=0, alu_b=0, alu_ctr=ADD.
//  FSM: IDLE -> MUL | DIV | DONE, then MUL/DIV -> DONE -> IDLE.
//   IDLE: start & ~flush & op=0 -> MUL; op=1 & src_b!=0 -> DIV.
//   IDLE: op=1 & src_b==0 -> DONE, with hi=src_a, lo=32'hFFFF_FFFF.
//   MUL/DIV: WIDTH cycles (counter 0..WIDTH-1), then DONE; writes hi/lo on the DONE edge.
//   DONE: done=1 for exactly one cycle, then IDLE; start in DONE is ignored.
//  Latency: start accepted at edge E0 -> iterations on E1..E32 -> done high in the cycle after E32.
//  Div-by-zero: done high in the cycle after E0.
//  Carry/borrow come from the MSBs of a, b, y, since the ALU has no carry out:
//   carry  = a31&b31 | (a31|b31)&~y31
//   borrow = ~a31&b31 | (~a31|b31)&y31
//  MUL, regs mcand, acc_hi, acc_lo; start loads mcand=src_a, acc_hi=0, acc_lo=src_b.
//   Drive: alu_a=acc_hi, alu_b=acc_lo[0]?mcand:0, ADD.
//   Update: {acc_hi,acc_lo} <= {carry, alu_y, acc_lo[31:1]}.
//  DIV, regs dvsr, rem, quo; start loads dvsr=src_b, rem=0, quo=src_a.
//   Let sh={rem[30:0],quo[31]}, top=rem[31].
//   Drive: alu_a=sh, alu_b=dvsr, SUB; ge = top | ~borrow.
//   Update: rem <= ge?alu_y:sh; quo <= {quo[30:0],ge}.
//  hi/lo hold their value from DONE until the next DONE; they are not disturbed by flush or a new start.
//  flush: from any state -> IDLE next edge; no done; hi/lo unchanged. flush beats start in IDLE.
//  rst mid-op: same as reset; hi/lo cleared to 0.
//  Unknown op values cannot occur (1-bit op). busy is registered-state decode; no combinational path start->busy.
// STRUCTURE
//  Shared include alu_defs.vh: ALU_AND=4'b0000, ALU_OR=4'b0001, ALU_ADD=4'b0010, ALU_SUB=4'b0110, ALU_SLT=4'b0111, ALU_NOR=4'b1100.
//  The same include holds FSM state encodings S_IDLE/S_MUL/S_DIV/S_DONE (2-bit) and OP_MULTU/OP_DIVU.
//  One sub-module: muldiv_flag, combinational carry/borrow from (a31,b31,y31); reused in tests.
//  ALU itself instantiated outside, in EX stage; this block never instantiates it.
// TESTING
//  Bench instantiates muldiv_seq + alu back-to-back; checks cycle counts against a free-running counter.
//  1. MULTU 0xFFFFFFFF*0xFFFFFFFF -> done 33 cycles after start, hi=0xFFFFFFFE, lo=0x00000001.
//  2. DIVU 100/7 -> lo=14, hi=2; DIVU 0xFFFFFFFF/1 -> lo=0xFFFFFFFF, hi=0 (exercises top-bit path).
//  3. DIVU 5/0 -> done next cycle after start, hi=5, lo=0xFFFFFFFF; busy high 1 cycle only.
//  4. Start MULTU 3*4 (hi/lo=0,12), then MULTU 7*9 flushed at iteration 10 -> busy low next edge, no done, hi/lo stay 0,12.
//  5. start pulsed during MUL and during DONE -> ignored; single done; alu_ctr=0010 whenever IDLE.
//  6. rst asserted mid-DIV -> next cycle busy=0, done=0, hi=lo=0; a following DIVU 9/2 gives lo=4, hi=1.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the multi-cycle MULTU/DIVU sequencer: ALU control
// codes, FSM state encoding and operation select values.
package muldiv_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic OP_MULTU = 1'b0;
  localparam logic OP_DIVU  = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MUL  = 2'b01,
    S_DIV  = 2'b10,
    S_DONE = 2'b11
  } state_t;

endpackage

// File: rtl/muldiv_flag.sv
// Recovers carry-out of an add and borrow-out of a subtract from the operand
// and result MSBs, since the shared ALU exposes no carry flag.
module muldiv_flag (
  input  logic a_msb,
  input  logic b_msb,
  input  logic y_msb,
  output logic carry,
  output logic borrow
);

  assign carry  = (a_msb & b_msb) | ((a_msb | b_msb) & ~y_msb);
  assign borrow = (~a_msb & b_msb) | ((~a_msb | b_msb) & y_msb);

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle unsigned MULTU/DIVU sequencer that time-shares the EX-stage ALU:
// one shift-add or restoring-divide iteration per cycle, results into hi/lo.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_ctr,
  input  logic [WIDTH-1:0] alu_y
);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  // MUL and DIV never overlap, so they share one register set:
  // opnd = mcand/dvsr, part_hi = acc_hi/rem, part_lo = acc_lo/quo.
  logic [WIDTH-1:0]   opnd;
  logic [WIDTH-1:0]   part_hi;
  logic [WIDTH-1:0]   part_lo;

  logic [WIDTH-1:0]   sh;
  logic               carry;
  logic               borrow;
  logic               ge;
  logic               last;
  logic [WIDTH-1:0]   mul_hi_nx;
  logic [WIDTH-1:0]   mul_lo_nx;
  logic [WIDTH-1:0]   div_hi_nx;
  logic [WIDTH-1:0]   div_lo_nx;

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  // Partial remainder shifted left by one, pulling in the next dividend bit.
  assign sh   = {part_hi[WIDTH-2:0], part_lo[WIDTH-1]};
  assign last = (cnt == CNT_W'(WIDTH - 1));

  always_comb begin
    // NOTE: every output gets a default before the case so no latch is inferred.
    alu_a   = '0;
    alu_b   = '0;
    alu_ctr = ALU_ADD;
    case (state)
      S_MUL: begin
        alu_a = part_hi;
        alu_b = part_lo[0] ? opnd : '0;
      end
      S_DIV: begin
        alu_a   = sh;
        alu_b   = opnd;
        alu_ctr = ALU_SUB;
      end
      default: ;
    endcase
  end

  muldiv_flag u_flag (
    .a_msb (alu_a[WIDTH-1]),
    .b_msb (alu_b[WIDTH-1]),
    .y_msb (alu_y[WIDTH-1]),
    .carry (carry),
    .borrow(borrow)
  );

  // A set shifted-out top bit means the 33-bit partial remainder already exceeds dvsr.
  assign ge        = part_hi[WIDTH-1] | ~borrow;
  assign mul_hi_nx = {carry, alu_y[WIDTH-1:1]};
  assign mul_lo_nx = {alu_y[0], part_lo[WIDTH-1:1]};
  assign div_hi_nx = ge ? alu_y : sh;
  assign div_lo_nx = {part_lo[WIDTH-2:0], ge};

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      opnd    <= '0;
      part_hi <= '0;
      part_lo <= '0;
      hi      <= '0;
      lo      <= '0;
    end else if (flush) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            cnt <= '0;
            if (op == OP_MULTU) begin
              opnd    <= src_a;
              part_hi <= '0;
              part_lo <= src_b;
              state   <= S_MUL;
            end else if (src_b == '0) begin
              hi    <= src_a;
              lo    <= '1;
              state <= S_DONE;
            end else begin
              opnd    <= src_b;
              part_hi <= '0;
              part_lo <= src_a;
              state   <= S_DIV;
            end
          end
        end
        S_MUL: begin
          part_hi <= mul_hi_nx;
          part_lo <= mul_lo_nx;
          cnt     <= cnt + CNT_W'(1);
          if (last) begin
            hi    <= mul_hi_nx;
            lo    <= mul_lo_nx;
            state <= S_DONE;
          end
        end
        S_DIV: begin
          part_hi <= div_hi_nx;
          part_lo <= div_lo_nx;
          cnt     <= cnt + CNT_W'(1);
          if (last) begin
            hi    <= div_hi_nx;
            lo    <= div_lo_nx;
            state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
